// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   tx_state_t   : transmitter FSM state encoding
//   DATA_SIZE_*  : the supported frame data widths
//   MIN_PERIOD   : shortest allowed bit period, in clocks
//   frame_cfg_t  : clamped frame configuration (bits per frame, clocks per bit)
//   clamp_cfg()  : maps raw size/period inputs onto a legal frame_cfg_t
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam logic [3:0]  DATA_SIZE_5 = 4'd5;
  localparam logic [3:0]  DATA_SIZE_7 = 4'd7;
  localparam logic [3:0]  DATA_SIZE_8 = 4'd8;
  localparam logic [13:0] MIN_PERIOD  = 14'd2;

  typedef struct packed {
    logic [3:0]  size;
    logic [13:0] period;
  } frame_cfg_t;

  // Unsupported sizes fall back to 8 bits; periods below MIN_PERIOD are raised
  // to it so the receiver always has a mid-bit sample point.
  function automatic frame_cfg_t clamp_cfg(input logic [3:0]  size,
                                           input logic [13:0] period);
    frame_cfg_t cfg;
    case (size)
      DATA_SIZE_5, DATA_SIZE_7, DATA_SIZE_8: cfg.size = size;
      default:                               cfg.size = DATA_SIZE_8;
    endcase
    cfg.period = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    return cfg;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// ----------------------------------------------------------------------------
// tx_bit_timer
// Counts clocks within one serial bit and flags the last clock of the bit.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clear     : force the count back to zero (held while the line is idle)
//   enable    : advance the count this clock
//   period    : clocks per bit (already clamped to >= 2)
//   bit_end   : high on the final clock of the current bit (count == period-1)
// The counter wraps to zero by itself at bit_end, so each new bit or state
// entered on a bit boundary starts from a zero count.
// ----------------------------------------------------------------------------
module tx_bit_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [13:0] period,
  output logic        bit_end
);

  logic [13:0] count;

  assign bit_end = enable && (count == period - 14'd1);

  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_end ? '0 : count + 14'd1;
    end
  end

endmodule

// File: rtl/uart_tx_block.sv
// ----------------------------------------------------------------------------
// uart_tx_block
// Serial UART transmitter: start bit (0), data_size data bits LSB first,
// stop bit (1), each bit held for data_period clocks.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   tx_data      : byte to send (only [data_size-1:0] goes on the line)
//   tx_valid     : tx_data valid; accepted when tx_valid && tx_ready
//   tx_ready     : block can take a byte this cycle
//   data_size    : bits per frame (5, 7 or 8; anything else means 8)
//   data_period  : clocks per bit (0 and 1 mean 2)
//   serial_out   : registered serial line, idle high
//   tx_busy      : a frame is on the line
//   tx_done      : one-clock pulse on the final clock of the stop bit
// Build option:
//   UART_TX_BUFFER_EN : adds a one-entry holding buffer so a second byte can be
//                       accepted mid-frame and sent with no idle gap.
// All outputs are registered from the FSM state, so the line, tx_busy and
// tx_done trail the state register by one clock and stay mutually aligned.
// ----------------------------------------------------------------------------
module uart_tx_block
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [3:0]  data_size,
  input  logic [13:0] data_period,
  output logic        serial_out,
  output logic        tx_busy,
  output logic        tx_done
);

  tx_state_t  state, next_state;
  frame_cfg_t cfg;            // configuration of the frame on the line
  logic [7:0] shift;          // remaining data bits, LSB is the current bit
  logic [3:0] bit_idx;        // data bit being sent
  logic       bit_end;
  logic       accept;
  logic       load;           // frame registers take a new byte this clock
  logic [7:0] load_data;
  frame_cfg_t load_cfg;
  logic       line_d;

  assign accept = tx_valid && tx_ready;

`ifdef UART_TX_BUFFER_EN
  logic       buf_full;
  logic [7:0] buf_data;
  frame_cfg_t buf_cfg;

  assign tx_ready  = !buf_full;
  // The buffer drains whenever the FSM is ready to begin a frame: from IDLE,
  // or straight out of the stop bit for back-to-back frames.
  assign load      = buf_full &&
                     ((state == TX_IDLE) || ((state == TX_STOP) && bit_end));
  assign load_data = buf_data;
  assign load_cfg  = buf_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
    end else if (load) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data <= tx_data;
      buf_cfg  <= clamp_cfg(data_size, data_period);
    end
  end
`else
  assign tx_ready  = (state == TX_IDLE);
  assign load      = accept;
  assign load_data = tx_data;
  assign load_cfg  = clamp_cfg(data_size, data_period);
`endif

  tx_bit_timer u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == TX_IDLE),
    .enable  (state != TX_IDLE),
    .period  (cfg.period),
    .bit_end (bit_end)
  );

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    line_d     = 1'b1;
    case (state)
      TX_IDLE: begin
        if (load) next_state = TX_START;
      end
      TX_START: begin
        line_d = 1'b0;
        if (bit_end) next_state = TX_DATA;
      end
      TX_DATA: begin
        line_d = shift[0];
        if (bit_end && (bit_idx == cfg.size - 4'd1)) next_state = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) next_state = load ? TX_START : TX_IDLE;
      end
      default: next_state = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TX_IDLE;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      bit_idx    <= '0;
    end else begin
      state      <= next_state;
      serial_out <= line_d;
      tx_busy    <= (state != TX_IDLE);
      tx_done    <= (state == TX_STOP) && bit_end;
      if (state != TX_DATA) begin
        bit_idx <= '0;
      end else if (bit_end) begin
        bit_idx <= bit_idx + 4'd1;
      end
    end
  end

  // NOTE: the frame payload registers carry no reset; they are always loaded
  // before the FSM leaves IDLE, and only the control path needs a known state.
  always_ff @(posedge clk) begin
    if (load) begin
      shift <= load_data;
      cfg   <= load_cfg;
    end else if ((state == TX_DATA) && bit_end) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_block
// Self-checking bench for uart_tx_block. A reference model schedules, for each
// accepted byte, the expected line waveform, tx_busy and tx_done per clock,
// and the expected tx_ready, computed from frame arithmetic (start bit, data
// bits LSB first, stop bit, period clocks each). A simple mid-bit sampling
// receiver decodes the recorded line for the loopback pair 0x3C/0xC3.
// Define UART_TX_BUFFER_EN for both bench and RTL to test the buffered build.
// ----------------------------------------------------------------------------
module tb_uart_tx_block;

  localparam int MAXC = 12000;

`ifdef UART_TX_BUFFER_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [3:0]  data_size = 4'd8;
  logic [13:0] data_period = 14'd10;
  logic        serial_out;
  logic        tx_busy;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_tx_block dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .data_size   (data_size),
    .data_period (data_period),
    .serial_out  (serial_out),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   ready_from = 0;   // first cycle in which tx_ready is expected high
  int   last_end = 0;     // cycle of the final stop-bit clock of the last frame
  bit   accepted;
  logic exp_line [MAXC];
  logic exp_busy [MAXC];
  logic exp_done [MAXC];
  logic obs_line [MAXC];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_size(input logic [3:0] s);
    return (s == 4'd5 || s == 4'd7 || s == 4'd8) ? int'(s) : 8;
  endfunction

  function automatic int ref_period(input logic [13:0] p);
    return (p < 14'd2) ? 2 : int'(p);
  endfunction

  // Everything from cycle r onward returns to the idle line.
  task automatic wipe(input int r);
    for (int t = r; t < MAXC; t++) begin
      exp_line[t] = 1'b1;
      exp_busy[t] = 1'b0;
      exp_done[t] = 1'b0;
    end
    ready_from = r;
    last_end   = 0;
  endtask

  // Byte accepted at edge n: place its frame on the expected timeline.
  task automatic schedule(input int n);
    int s, p, len, start, bit_no;
    s   = ref_size(data_size);
    p   = ref_period(data_period);
    len = (2 + s) * p;
`ifdef UART_TX_BUFFER_EN
    start      = (n + 2 > last_end + 1) ? n + 2 : last_end + 1;
    ready_from = start - 1;
`else
    start      = n + 1;
    ready_from = start + len - 1;
`endif
    for (int k = 0; k < len; k++) begin
      if (start + k < MAXC) begin
        bit_no = k / p;
        if (bit_no == 0)      exp_line[start + k] = 1'b0;
        else if (bit_no <= s) exp_line[start + k] = tx_data[bit_no - 1];
        else                  exp_line[start + k] = 1'b1;
        exp_busy[start + k] = 1'b1;
      end
    end
    if (start + len - 1 < MAXC) exp_done[start + len - 1] = 1'b1;
    last_end = start + len - 1;
  endtask

  task automatic tick();
    bit acc;
    acc = tx_valid && (cyc >= ready_from) && !rst;
    accepted = 1'b0;
    @(posedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst) wipe(cyc);
    else if (acc) begin
      schedule(cyc);
      accepted = 1'b1;
    end
    #1;
    obs_line[cyc] = serial_out;
    check($sformatf("line@%0d", cyc),  32'(serial_out), 32'(exp_line[cyc]));
    check($sformatf("busy@%0d", cyc),  32'(tx_busy),    32'(exp_busy[cyc]));
    check($sformatf("done@%0d", cyc),  32'(tx_done),    32'(exp_done[cyc]));
    check($sformatf("ready@%0d", cyc), 32'(tx_ready),   32'(cyc >= ready_from));
  endtask

  // Present a byte and hold it until taken, then scramble the inputs so the
  // frame in flight must not depend on them.
  task automatic send(input logic [7:0] d, input logic [3:0] s,
                      input logic [13:0] p);
    int budget;
    tx_data     = d;
    data_size   = s;
    data_period = p;
    tx_valid    = 1'b1;
    budget      = 0;
    do begin
      tick();
      budget++;
    end while (!accepted && budget < 3000);
    if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
    tx_valid    = 1'b0;
    tx_data     = 8'($urandom);
    data_size   = 4'($urandom);
    data_period = 14'($urandom_range(0, 20));
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((cyc <= last_end || cyc < ready_from) && b < 5000) begin
      tick();
      b++;
    end
    if (b >= 5000) check("idle_timeout", 32'(b), 32'd0);
    tick();
  endtask

  // Mid-bit sampling receiver over the recorded line.
  task automatic decode(input int from, input int p, output int start,
                        output logic [7:0] data, output logic stop_bit);
    int t, mid;
    t = from;
    while (t < cyc && obs_line[t] !== 1'b0) t++;
    start = t;
    mid   = start + p / 2;
    for (int i = 0; i < 8; i++) begin
      data[i] = (mid + (i + 1) * p < cyc) ? obs_line[mid + (i + 1) * p] : 1'bx;
    end
    stop_bit = (mid + 9 * p < cyc) ? obs_line[mid + 9 * p] : 1'bx;
  endtask

  initial begin
    int         s0, s1, lb_from;
    logic [7:0] d0, d1;
    logic       st0, st1;
    logic [3:0] sizes [6];
    sizes = '{4'd5, 4'd7, 4'd8, 4'd3, 4'd0, 4'd15};

    wipe(0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 0xA5, 8 bits, 10 clocks per bit: 100-clock frame.
    send(8'hA5, 4'd8, 14'd10);
    wait_idle();

    // Size 5 then 7 with all-ones data: bits above the size never appear.
    send(8'hFF, 4'd5, 14'd4);
    wait_idle();
    send(8'hFF, 4'd7, 14'd4);
    wait_idle();

    // Period clamps and size clamp.
    send(8'h5A, 4'd8, 14'd0);
    wait_idle();
    send(8'hC3, 4'd8, 14'd1);
    wait_idle();
    send(8'h96, 4'd3, 14'd3);
    wait_idle();

    // Reset while in the data bits, with a second byte offered mid-frame.
    send(8'hA5, 4'd8, 14'd10);
    repeat (20) tick();
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    wait_idle();

    // Back-to-back loopback pair.
    lb_from = cyc + 1;
    send(8'h3C, 4'd8, 14'd6);
    send(8'hC3, 4'd8, 14'd6);
    wait_idle();
    decode(lb_from, 6, s0, d0, st0);
    decode(s0 + 60, 6, s1, d1, st1);
    check("lb_data0", 32'(d0), 32'h3C);
    check("lb_stop0", 32'(st0), 32'd1);
    check("lb_data1", 32'(d1), 32'hC3);
    check("lb_stop1", 32'(st1), 32'd1);
    check("lb_gap", 32'(s1 - s0 - 60), 32'(EXP_GAP));

    // Randomized frames with random gaps.
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), sizes[$urandom_range(0, 5)],
           14'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_block.md
# uart_tx_block

Serial transmitter that feeds the UART receive path's `serial_in`. It accepts a parallel byte via a valid/ready handshake and emits one frame: start bit (0), `data_size` data bits LSB first, stop bit (1), with each bit held for `data_period` clocks. Its frame format and bit-period configuration match the receiver, so a loopback of `serial_out` to `serial_in` round-trips data.

## Interface
- No parameters; widths are fixed by the receive path.
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `tx_data`  in  8  byte to send; only bits `[data_size-1:0]` are transmitted
- `tx_valid`  in  1  `tx_data` is valid; accepted when `tx_valid && tx_ready` at a rising edge
- `tx_ready`  out  1  block can accept a byte this cycle
- `data_size`  in  4  bits per frame: 5, 7 or 8; any other value is treated as 8
- `data_period`  in  14  clocks per bit; values 0 and 1 are treated as 2
- `serial_out`  out  1  serial line; idle high
- `tx_busy`  out  1  a frame is in progress (state ≠ IDLE)
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START on accept. On accept, latch `tx_data`, clamped size and clamped period into frame registers. Input changes mid-frame have no effect on the current frame.
- START: `serial_out`=0 for one period, then go to DATA with bit index 0.
- DATA: `serial_out`=`shift[0]` for one period per bit, then shift right. After bit `size-1`, go to STOP.
- STOP: `serial_out`=1 for one period. On the last cycle of the period, pulse `tx_done` and go to IDLE. If a byte is pending (see Configuration), go to START instead.
- Bit timer: counts 0..period-1. It is cleared on every state entry and on each DATA bit boundary. Bit boundary = counter reaches period-1.
- `serial_out` is registered and driven high in IDLE.
- `tx_ready` without the buffer = (state == IDLE).
- Reset values: `serial_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state IDLE, counters 0, buffer empty.
- Reset mid-frame: the frame is abandoned, the line is high the cycle after reset, and any pending byte is discarded.
- `tx_valid` while not ready: ignored. The upstream block must hold the byte until it sees ready.

## Timing
- Accept at edge N → `serial_out` falls at edge N+1; `tx_busy` rises at N+1.
- Frame length is exactly (2 + size) × period clocks of non-idle line.
- `tx_done` is high during the final clock of the stop bit. The block is in IDLE from the next edge.
- Without the buffer, back-to-back frames have a minimum of one idle-high clock between stop bit and next start bit. That clock is the IDLE cycle in which the accept occurs.
- Latency from accept to the first data bit on the line is 1 + period clocks.

## Configuration
- Macro `UART_TX_BUFFER_EN` enables a one-entry holding buffer.
- **With the macro:**
  - `tx_ready` = buffer empty.
  - Accepts go into the buffer at any state. A byte accepted in IDLE moves to the frame registers on the next edge, adding one clock to accept→start latency.
  - At STOP completion with the buffer full, the FSM goes directly to START. There are zero idle cycles between frames, and `tx_done` still pulses.
  - An accept coincident with STOP completion while the buffer is empty is held and sent after one IDLE cycle.
  - Size and period are latched when the buffer loads, not when the frame starts.
- **Without the macro:** the block has no buffer storage and behaves as described above.

## Structure
- Package `uart_pkg`:
  - FSM state enum `tx_state_t`
  - constants `DATA_SIZE_5`=4'd5, `DATA_SIZE_7`=4'd7, `DATA_SIZE_8`=4'd8
  - `MIN_PERIOD`=14'd2
  - the size/period clamp as a function, shared with the receive path
- Sub-module `tx_bit_timer` contains the period counter with `clear`/`enable` inputs and a `bit_end` output.

## Test plan
- Reset, then send 8'hA5 with size 8 and period 10 → line 0, then 1,0,1,0,0,1,0,1 and a stop 1, each bit exactly 10 clocks; `tx_done` pulses once at clock 100 after start.
- Send 8'hFF with size 5 and period 4 → 5 data ones, 28 non-idle clocks total. Send again with size 7 → 36 clocks; bit 7 is never driven.
- Period 0 and period 1 → both produce 2-clock bits. Size 4'd3 → 8 data bits.
- Change `data_size` and `data_period` mid-frame → the current frame is unchanged, and the next frame uses the new values.
- Assert reset in the DATA state → `serial_out`=1 and `tx_busy`=0 the next cycle, with no `tx_done`.
- Without `UART_TX_BUFFER_EN`, loop back to `rcv_block` with 0x3C then 0xC3 sent back-to-back → `rx_data` matches and there is no framing error. With `UART_TX_BUFFER_EN`, there is no idle gap between the two frames.
